// File: rtl/cpu_pkg.sv
// Shared CPU definitions used by the bit-serial datapath helpers.
// Contents:
//   t2sm_state_t  - control state of twos_to_signmag (IDLE, BUSY, DONE)
//   CPU_WORD_SIZE - native CPU word width, default operand width
package cpu_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } t2sm_state_t;

    localparam int unsigned CPU_WORD_SIZE = 16;

endpackage : cpu_pkg

// File: rtl/serial_negate_cell.sv
// One-bit serial negate cell: copies bits through the first 1, then inverts
// the rest. That yields the magnitude of a negative operand, LSB first.
// Ports:
//   clk, rst_n - clock, async active-low reset
//   i_b        - current operand bit (LSB first)
//   i_sign     - operand is negative; when 0 the bit passes through
//   i_clr      - clear the seen-one state (new operand accepted)
//   i_en       - a bit is being processed this cycle
//   o_bit_c    - combinational result bit
module serial_negate_cell (
    input  logic clk,
    input  logic rst_n,
    input  logic i_b,
    input  logic i_sign,
    input  logic i_clr,
    input  logic i_en,
    output logic o_bit_c
);

    logic r_seen_one;

    // Remember whether a 1 has already passed on a negative operand
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_seen_one <= 1'b0;
        end else if (i_clr) begin
            r_seen_one <= 1'b0;
        end else if (i_en && i_sign) begin
            r_seen_one <= r_seen_one | i_b;
        end
    end

    assign o_bit_c = (i_sign && r_seen_one) ? ~i_b : i_b;

endmodule : serial_negate_cell

// File: rtl/twos_to_signmag.sv
// Bit-serial two's-complement to sign-magnitude converter, one bit per clock.
// Optional feature: define TWOS_TO_SIGNMAG_OVF_EN to add the ovf output. It
// flags the most negative operand, whose magnitude needs the full width.
// Ports:
//   clk, rst_n           - clock, async active-low reset
//   in_valid, in_ready   - operand handshake; in_ready is high in IDLE only
//   in                   - two's-complement operand
//   out_valid, out_ready - result handshake; out_valid is high in DONE only
//   sign, mag            - result, held until the next accept
//   ovf                  - (TWOS_TO_SIGNMAG_OVF_EN) sign & mag MSB
module twos_to_signmag
    import cpu_pkg::*;
#(
    parameter int unsigned size = CPU_WORD_SIZE
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [size-1:0] in,
    output logic            out_valid,
    input  logic            out_ready,
    output logic            sign,
`ifdef TWOS_TO_SIGNMAG_OVF_EN
    output logic            ovf,
`endif
    output logic [size-1:0] mag
);

    localparam int unsigned CW = (size > 1) ? $clog2(size) : 1;

    t2sm_state_t     r_state;
    logic [size-1:0] r_sr;
    logic [size-1:0] r_mag;
    logic [CW-1:0]   r_cnt;
    logic            r_sign;
    logic            w_accept;
    logic            w_busy;
    logic            w_o;
`ifdef TWOS_TO_SIGNMAG_OVF_EN
    logic            r_ovf;
`endif

    assign w_accept = (r_state == IDLE) && in_valid;
    assign w_busy   = (r_state == BUSY);

    serial_negate_cell u_cell (
        .clk     (clk),
        .rst_n   (rst_n),
        .i_b     (r_sr[0]),
        .i_sign  (r_sign),
        .i_clr   (w_accept),
        .i_en    (w_busy),
        .o_bit_c (w_o)
    );

    // Control FSM with the operand shifter, counter and result registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= IDLE;
            r_sr    <= '0;
            r_mag   <= '0;
            r_cnt   <= '0;
            r_sign  <= 1'b0;
`ifdef TWOS_TO_SIGNMAG_OVF_EN
            r_ovf   <= 1'b0;
`endif
        end else begin
            case (r_state)
                IDLE: begin
                    if (in_valid) begin
                        r_sr    <= in;
                        r_sign  <= in[size-1];
                        r_cnt   <= '0;
                        r_state <= BUSY;
                    end
                end
                BUSY: begin
                    // Result enters at the MSB so bit k lands at mag[k] after size shifts
                    r_sr  <= r_sr >> 1;
                    r_mag <= {w_o, r_mag[size-1:1]};
                    if (r_cnt == CW'(size - 1)) begin
                        r_state <= DONE;
`ifdef TWOS_TO_SIGNMAG_OVF_EN
                        r_ovf   <= r_sign & w_o;
`endif
                    end else begin
                        r_cnt <= r_cnt + CW'(1);
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        r_state <= IDLE;
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    assign in_ready  = (r_state == IDLE);
    assign out_valid = (r_state == DONE);
    assign sign      = r_sign;
    assign mag       = r_mag;
`ifdef TWOS_TO_SIGNMAG_OVF_EN
    assign ovf       = r_ovf;
`endif

endmodule : twos_to_signmag
